// File: rtl/tm1638_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_display_arbiter
// Purpose  : Round-robin sharing of one TM1638 board (8 digits, 8 LEDs,
//            8 keys) among n_req requesters. Each owner keeps the board for
//            at least hold_cycles clocks. Ownership changes only on a
//            refresh-frame boundary (frame_done), so no mixed frame is shown.
// Options  : TM1638_DISPLAY_ARBITER_PREEMPT_EN - requester 0 (diagnostics)
//            preempts any other owner and wins the next arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tm1638_display_arbiter #(
  parameter int n_req       = 2,
  parameter int w_digit     = 8,
  parameter int hold_cycles = 12500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req,
  output logic [n_req-1:0]         gnt,
  input  logic [8*n_req-1:0]       src_hgfedcba,
  input  logic [w_digit*n_req-1:0] src_digit,
  input  logic [8*n_req-1:0]       src_led,
  input  logic                     frame_done,
  input  logic [7:0]               key_in,
  output logic [7:0]               out_hgfedcba,
  output logic [w_digit-1:0]       out_digit,
  output logic [7:0]               out_led,
  output logic [8*n_req-1:0]       key_out
);

  localparam int IW = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int CW = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  localparam logic [CW-1:0] C_HOLD_LAST = CW'(hold_cycles - 1);
  // The owner register doubles as the round-robin pointer; starting at the
  // top index makes index 0 the first winner after reset.
  localparam logic [IW-1:0] C_RR_RESET  = IW'(n_req - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [n_req-1:0]       gnt_q, gnt_d;
  logic [7:0]             seg_q, seg_d;
  logic [w_digit-1:0]     digit_q, digit_d;
  logic [7:0]             led_q, led_d;
  logic [8*n_req-1:0]     key_q, key_d;

  logic [IW-1:0]          w_pick;
  logic [n_req-1:0]       w_others;
  logic                   w_owner_req;
  logic                   w_preempt;

  // Cyclic search starting just after ptr; ptr itself is examined last.
  function automatic logic [IW-1:0] rr_pick(input logic [n_req-1:0] r,
                                            input logic [IW-1:0]    ptr);
    logic [IW:0] idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= n_req; i++) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(n_req)) begin
        idx = idx - (IW+1)'(n_req);
      end
      if (!found && r[idx[IW-1:0]]) begin
        found   = 1'b1;
        rr_pick = idx[IW-1:0];
      end
    end
`ifdef TM1638_DISPLAY_ARBITER_PREEMPT_EN
    if (r[0]) begin
      rr_pick = '0;
    end
`endif
  endfunction

  function automatic logic [n_req-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign w_pick      = rr_pick(req, owner_q);
  assign w_others    = req & ~onehot(owner_q);
  assign w_owner_req = req[owner_q];
`ifdef TM1638_DISPLAY_ARBITER_PREEMPT_EN
  assign w_preempt   = req[0] && (owner_q != '0);
`else
  assign w_preempt   = 1'b0;
`endif

  // Ownership state machine: decides when a switch is wanted and performs
  // it only on a frame boundary.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (frame_done && (|req)) begin
          owner_d = w_pick;
          gnt_d   = onehot(w_pick);
          cnt_d   = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // A frame_done here is deliberately ignored; a switch requested in
        // this cycle waits for the following pulse.
        if (!w_owner_req || w_preempt ||
            ((cnt_q == C_HOLD_LAST) && (|w_others))) begin
          state_d = ST_PENDING;
        end else if (cnt_q != C_HOLD_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PENDING: begin
        if (frame_done) begin
          if (|req) begin
            owner_d = w_pick;
            gnt_d   = onehot(w_pick);
            cnt_d   = '0;
            state_d = ST_OWN;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output steering follows the registered grant, one cycle behind it.
  always_comb begin
    seg_d   = '0;
    digit_d = '0;
    led_d   = '0;
    key_d   = '0;
    for (int i = 0; i < n_req; i++) begin
      if (gnt_q[i]) begin
        seg_d   = seg_d   | src_hgfedcba[8*i +: 8];
        digit_d = digit_d | src_digit[w_digit*i +: w_digit];
        led_d   = led_d   | src_led[8*i +: 8];
        key_d[8*i +: 8] = key_in;
      end
    end
  end

  // All state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= C_RR_RESET;
      cnt_q   <= '0;
      gnt_q   <= '0;
      seg_q   <= '0;
      digit_q <= '0;
      led_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      seg_q   <= seg_d;
      digit_q <= digit_d;
      led_q   <= led_d;
      key_q   <= key_d;
    end
  end

  assign gnt          = gnt_q;
  assign out_hgfedcba = seg_q;
  assign out_digit    = digit_q;
  assign out_led      = led_q;
  assign key_out      = key_q;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_display_arbiter
// Purpose  : Directed bench for tm1638_display_arbiter with an ownership
//            model checked every cycle plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm1638_display_arbiter;

  localparam int N    = 2;
  localparam int W    = 8;
  localparam int HOLD = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [8*N-1:0]   src_hgfedcba;
  logic [W*N-1:0]   src_digit;
  logic [8*N-1:0]   src_led;
  logic             frame_done;
  logic [7:0]       key_in;
  logic [7:0]       out_hgfedcba;
  logic [W-1:0]     out_digit;
  logic [7:0]       out_led;
  logic [8*N-1:0]   key_out;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  tm1638_display_arbiter #(
    .n_req(N), .w_digit(W), .hold_cycles(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .src_hgfedcba(src_hgfedcba), .src_digit(src_digit), .src_led(src_led),
    .frame_done(frame_done), .key_in(key_in),
    .out_hgfedcba(out_hgfedcba), .out_digit(out_digit), .out_led(out_led),
    .key_out(key_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_owner;   // -1 means nobody owns the board
  int           m_rr;
  int           m_age;
  bit           m_pend;
  bit           m_others;
  logic [N-1:0] e_gnt = '0;
  logic [7:0]   e_seg = '0;
  logic [W-1:0] e_dig = '0;
  logic [7:0]   e_led = '0;
  logic [8*N-1:0] e_key = '0;

  function automatic int m_pick(input logic [N-1:0] r, input int rr);
`ifdef TM1638_DISPLAY_ARBITER_PREEMPT_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return rr;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_rr = N - 1; m_age = 0; m_pend = 0;
      e_seg = '0; e_dig = '0; e_led = '0; e_key = '0;
    end else begin
      e_seg = '0; e_dig = '0; e_led = '0; e_key = '0;
      if (m_owner >= 0) begin
        e_seg = src_hgfedcba[8*m_owner +: 8];
        e_dig = src_digit[W*m_owner +: W];
        e_led = src_led[8*m_owner +: 8];
        e_key[8*m_owner +: 8] = key_in;
      end
      if (m_owner < 0) begin
        if (frame_done && req != '0) begin
          m_owner = m_pick(req, m_rr); m_rr = m_owner; m_age = 0; m_pend = 0;
        end
      end else if (!m_pend) begin
        m_others = 0;
        for (int k = 0; k < N; k++) if (k != m_owner && req[k]) m_others = 1;
        if (!req[m_owner] || (m_age >= HOLD - 1 && m_others)) m_pend = 1;
`ifdef TM1638_DISPLAY_ARBITER_PREEMPT_EN
        else if (req[0] && m_owner != 0) m_pend = 1;
`endif
        else m_age++;
      end else if (frame_done) begin
        if (req != '0) begin
          m_owner = m_pick(req, m_owner); m_rr = m_owner; m_age = 0; m_pend = 0;
        end else begin
          m_owner = -1; m_pend = 0;
        end
      end
    end
    e_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt",          64'(gnt),          64'(e_gnt));
      chk("out_hgfedcba", 64'(out_hgfedcba), 64'(e_seg));
      chk("out_digit",    64'(out_digit),    64'(e_dig));
      chk("out_led",      64'(out_led),      64'(e_led));
      chk("key_out",      64'(key_out),      64'(e_key));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit fd);
    @(negedge clk);
    frame_done = fd;
  endtask

  task automatic frame(input int len);
    repeat (len - 1) tick(1'b0);
    tick(1'b1);
  endtask

  initial begin
    rst = 1'b1; req = '0; frame_done = 1'b0; key_in = 8'h05;
    src_led      = {8'hB2, 8'hA1};
    src_hgfedcba = {8'h3C, 8'h5A};
    src_digit    = {8'h0F, 8'hF0};
    repeat (3) tick(1'b0);
    chk_en = 1'b1;
    chk("reset_gnt", 64'(gnt), 64'h0);
    chk("reset_led", 64'(out_led), 64'h0);
    chk("reset_key", 64'(key_out), 64'h0);
    rst = 1'b0;

    // first grant goes to requester 0
    req = 2'b01;
    frame(40); tick(1'b0);
    chk("first_gnt", 64'(gnt), 64'h1);
    tick(1'b0);
    chk("first_led", 64'(out_led), 64'hA1);
    chk("first_seg", 64'(out_hgfedcba), 64'h5A);
    chk("first_dig", 64'(out_digit), 64'hF0);
    chk("first_key", 64'(key_out), 64'h0005);
    src_led = {8'hB2, 8'hC3};
    tick(1'b0);
    chk("src_follow", 64'(out_led), 64'hC3);

    // both requesting: alternate 1, then 0
    req = 2'b11;
    frame(40); tick(1'b0);
    chk("rr_to_1", 64'(gnt), 64'h2);
    tick(1'b0);
    chk("rr_key1", 64'(key_out), 64'h0500);
    chk("rr_led1", 64'(out_led), 64'hB2);
    frame(40); tick(1'b0);
    chk("rr_to_0", 64'(gnt), 64'h1);

    // owner 0 drops early; short frame still hands over
    tick(1'b0);
    req = 2'b10;
    frame(6); tick(1'b0);
    chk("drop_gnt", 64'(gnt), 64'h2);

    // release everything on a pulse while pending
    req = 2'b11;
    repeat (39) tick(1'b0);
    tick(1'b1); req = 2'b00;
    tick(1'b0);
    chk("idle_gnt", 64'(gnt), 64'h0);
    tick(1'b0);
    chk("idle_led", 64'(out_led), 64'h0);
    chk("idle_key", 64'(key_out), 64'h0);

    // reset while pending
    req = 2'b01;
    frame(40); tick(1'b0);
    chk("regrant0", 64'(gnt), 64'h1);
    req = 2'b11;
    repeat (20) tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_led", 64'(out_led), 64'h0);
    rst = 1'b0;
    frame(40); tick(1'b0);
    chk("post_rst_gnt", 64'(gnt), 64'h1);

    // requester 0 rising early in requester 1's slot
    req = 2'b10;
    frame(6); tick(1'b0);
    chk("own1", 64'(gnt), 64'h2);
    tick(1'b0);
    req = 2'b11;
    frame(10); tick(1'b0);
`ifdef TM1638_DISPLAY_ARBITER_PREEMPT_EN
    chk("preempt_gnt", 64'(gnt), 64'h1);
`else
    chk("no_preempt_gnt", 64'(gnt), 64'h2);
    frame(40); tick(1'b0);
    chk("hold_then_0", 64'(gnt), 64'h1);
`endif

    repeat (5) tick(1'b0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tm1638_display_arbiter.md
# tm1638_display_arbiter

Shares the single TM1638 board (eight-digit seven-segment display, eight LEDs, eight keys) among `n_req` requesters, such as the lab design and a self-diagnostics source driving the sticky-failure indication. It uses round-robin arbitration with a minimum ownership slot. Ownership changes only on a TM1638 refresh-frame boundary, so the display never shows a mixed frame. It sits between the requesters and `tm1638_board_controller`.

## Interface
- `n_req`, 2: number of requesters (2..8).
- `w_digit`, 8: digit-enable width per requester.
- `hold_cycles`, 12500000: minimum ownership slot in clk cycles (0.5 s at 25 MHz); must be ≥ 1.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  n_req  request, one bit per requester; level-sensitive.
- `gnt`  out  n_req  one-hot grant, or all-zero; registered.
- `src_hgfedcba`  in  8·n_req  segment data; requester i occupies bits [8i+7:8i].
- `src_digit`  in  w_digit·n_req  digit enables; requester i occupies bits [w_digit·i+w_digit−1 : w_digit·i].
- `src_led`  in  8·n_req  LED data; requester i occupies bits [8i+7:8i].
- `frame_done`  in  1  one-cycle pulse from the TM1638 controller at the end of each refresh frame.
- `key_in`  in  8  key state from the TM1638 controller.
- `out_hgfedcba`  out  8  segment data to the controller; registered.
- `out_digit`  out  w_digit  digit enables to the controller; registered.
- `out_led`  out  8  LED data to the controller; registered.
- `key_out`  out  8·n_req  key state routed to the owner; registered; all other slices are 0.

## Operation
- State machine has three states:
  - IDLE: no owner; `gnt`=0; all display outputs 0.
  - OWN: owner fixed; hold counter counts up from 0.
  - PENDING: a switch is wanted; the current owner keeps `gnt` until `frame_done`.
- Transitions:
  - IDLE → OWN on `frame_done` with any `req` set.
  - OWN → PENDING when the owner drops `req`. This applies regardless of the counter.
  - OWN → PENDING when the counter has reached `hold_cycles−1` and any other `req` bit is set.
  - Otherwise in OWN, the counter saturates at `hold_cycles−1`.
  - PENDING on `frame_done`: run arbitration. A winner moves to OWN with the counter cleared. No requester moves to IDLE with `gnt`=0.
- Arbitration rule: search cyclically starting at index `owner+1`, taking the first set `req` bit. The current owner is examined last, so a lone requester keeps ownership.
- Round-robin pointer: equals the last owner. Reset value is `n_req−1`, so index 0 wins first.
- Arbitration uses `req` as sampled on the `frame_done` edge. A request deasserted in the same cycle is not granted.
- If the owner re-asserts `req` while in PENDING, the state stays PENDING; arbitration still resolves it.
- Counter width is `$clog2(hold_cycles)`, minimum 1 bit.

## Timing
- Reset value of every output is 0; state resets to IDLE.
- Reset mid-operation: `gnt` and all outputs are 0 on the cycle after `rst` is sampled high.
- `gnt` changes on the cycle after `frame_done` is sampled.
- Display outputs and `key_out` take one cycle from `gnt`:
  - they reflect the new owner two cycles after `frame_done`;
  - they reflect a source data change one cycle after it when ownership is stable.
- Hold expiry: earliest switch request is `hold_cycles` cycles after entering OWN; the actual switch is at the next `frame_done`.
- `frame_done` arriving in the same cycle as OWN → PENDING is not used; the switch waits for the following pulse.

## Configuration
- Macro: `TM1638_DISPLAY_ARBITER_PREEMPT_EN`.
- Defined:
  - `req[0]` (diagnostics) set while the owner is not 0 forces OWN → PENDING immediately, ignoring the hold counter.
  - At the next `frame_done`, index 0 wins regardless of the round-robin pointer.
- Undefined: index 0 is an ordinary round-robin requester.

## Test plan
- Reset, `n_req`=2, `hold_cycles`=16, `frame_done` every 40 cycles: all outputs 0. Set `req`=01 → `gnt`=01 one cycle after the first pulse; `out_led`=`src_led[7:0]` one cycle later.
- `req`=11 held: owner alternates 0,1,0 on successive pulses, with each slot ≥ 16 cycles. Key 0x05 on `key_in` appears only in the owner's `key_out` slice; the other slice is 0.
- Owner 0 drops `req` at cycle 3 of its slot while `req[1]`=1 → `gnt`=10 after the next pulse, not waiting for hold.
- `req` drops to 00 with a `frame_done` pulse in the same cycle → IDLE; `gnt`=00; outputs 0.
- Assert `rst` while in PENDING → `gnt`=0 next cycle; after release, the first grant goes to index 0.
- With the macro defined, owner 1 at cycle 2 of its slot and `req[0]` rises → `gnt`=01 after the next pulse. Without the macro, 0 is granted only after 16 cycles plus a pulse.
